// File: rtl/usart_pkg.sv
// Shared types and constants for the 8E1 UART.
package usart_pkg;

    // Width of one character on the wire (data bits only).
    localparam int DATA_W = 8;

    // Bit period in system clocks, using integer truncation (50 MHz / 115200 = 434).
    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    localparam int DEFAULT_BAUD_DIV = baud_div(50_000_000, 115200);

    // Both the TX and RX machines walk through the same frame phases.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

endpackage

// File: rtl/usart_rx.sv
// Receive path: 2-FF synchroniser, mid-bit sampling FSM, parity/framing check,
// and the host-visible receive buffer with its ready and error flags.
module usart_rx
    import usart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rxd_i,
    input  logic              rdy_clr_i,
    output logic [DATA_W-1:0] data_o,
    output logic              rdy_o,
    output logic              n_int_o,
    output state_e            state_o
);

    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);

    logic              sync1_q, sync2_q, prev_q;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rdy_q, rdy_d;
    logic              n_int_q, n_int_d;
    logic              frame_ok, frame_err;
    logic              rx_s;

    // The line is only ever looked at after the second flop; prev_q gives edge detection.
    assign rx_s = sync2_q;

    // Synchroniser and one-cycle history of the synchronised line; idles high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Receive FSM and buffer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            n_int_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            n_int_q <= n_int_d;
        end
    end

    // Next state: half a bit into START to reach mid-bit, then one full bit per sample.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        frame_ok  = 1'b0;
        frame_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (prev_q && !rx_s) begin
                    state_d = ST_START;
                    cnt_d   = HALF_M1;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        // Line went back high before mid-start: treat as a glitch.
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = DIV_M1;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    cnt_d   = DIV_M1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (cnt_q == '0) begin
                    par_d   = rx_s;
                    cnt_d   = DIV_M1;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    // Back to IDLE right at the stop sample so a new start edge can follow.
                    state_d = ST_IDLE;
                    if (rx_s && !(^{shift_q, par_q})) begin
                        frame_ok = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Host flags: rdy_clr clears, a frame completing on the same edge wins.
    always_comb begin
        data_d  = data_q;
        rdy_d   = rdy_q;
        n_int_d = n_int_q;
        if (rdy_clr_i) begin
            rdy_d   = 1'b0;
            n_int_d = 1'b1;
        end
        if (frame_ok) begin
            data_d = shift_q;
            rdy_d  = 1'b1;
        end
        if (frame_err) begin
            n_int_d = 1'b0;
        end
    end

    assign data_o  = data_q;
    assign rdy_o   = rdy_q;
    assign n_int_o = n_int_q;
    assign state_o = state_q;

endmodule

// File: rtl/usart.sv
// Full-duplex 8E1 UART between a byte-wide host bus and the serial pins.
// The transmitter lives here; the receiver is the usart_rx sub-module.
//
// Host handshake: a write is accepted at any rising edge where n_WR=0 and
// Tx_RDY=1; writes while Tx_RDY=0 are dropped. Rx_RDY=1 means DATA_OUT holds
// a fresh byte until rdy_clr=1 is seen at an edge (a new good frame overwrites).
module usart
    import usart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic              CLK50M,
    input  logic              RST,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              n_WR,
    output logic              TxD,
    output logic              Tx_RDY,
    input  logic              RxD,
    output logic              Rx_RDY,
    input  logic              rdy_clr,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              n_INT,
    output state_e            dbg_tx_state_o,
    output state_e            dbg_rx_state_o
);

    localparam int BAUD_DIV = baud_div(CLK_HZ, BAUD);
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(BAUD_DIV - 1);

    state_e            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              tx_par_q, tx_par_d;
    logic              txd_q, txd_d;

    // Transmitter registers; TxD is registered so the pin never glitches.
    always_ff @(posedge CLK50M) begin
        if (RST) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
        end
    end

    // Transmit FSM: each phase holds TxD for a full bit period, then loads the next bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;

        case (tx_state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (!n_WR) begin
                    tx_state_d = ST_START;
                    tx_shift_d = DATA_IN;
                    tx_par_d   = ^DATA_IN;
                    tx_cnt_d   = DIV_M1;
                    tx_bit_d   = 3'd0;
                    txd_d      = 1'b0;
                end
            end
            ST_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = ST_DATA;
                    tx_cnt_d   = DIV_M1;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = DIV_M1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_PARITY;
                        txd_d      = tx_par_q;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = ST_STOP;
                    tx_cnt_d   = DIV_M1;
                    txd_d      = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = ST_IDLE;
                    txd_d      = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                tx_state_d = ST_IDLE;
                txd_d      = 1'b1;
            end
        endcase
    end

    assign TxD            = txd_q;
    assign Tx_RDY         = (tx_state_q == ST_IDLE);
    assign dbg_tx_state_o = tx_state_q;

    usart_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk_i     (CLK50M),
        .rst_i     (RST),
        .rxd_i     (RxD),
        .rdy_clr_i (rdy_clr),
        .data_o    (DATA_OUT),
        .rdy_o     (Rx_RDY),
        .n_int_o   (n_INT),
        .state_o   (dbg_rx_state_o)
    );

endmodule

// File: tb/tb_usart.sv
// Self-checking bench for the usart top: transmit framing, receive at a
// slightly slow baud, error flags, glitch rejection and reset mid-frame.
module tb_usart;
    import usart_pkg::*;

    localparam int DIV      = 434;
    localparam int FRAME    = 11 * DIV;
    localparam int SLOW_DIV = 435;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       RST;
    logic [7:0] DATA_IN;
    logic       n_WR;
    logic       TxD;
    logic       Tx_RDY;
    logic       RxD;
    logic       Rx_RDY;
    logic       rdy_clr;
    logic [7:0] DATA_OUT;
    logic       n_INT;
    state_e     dbg_tx_state;
    state_e     dbg_rx_state;

    always #10 clk = ~clk;

    usart dut (
        .CLK50M         (clk),
        .RST            (RST),
        .DATA_IN        (DATA_IN),
        .n_WR           (n_WR),
        .TxD            (TxD),
        .Tx_RDY         (Tx_RDY),
        .RxD            (RxD),
        .Rx_RDY         (Rx_RDY),
        .rdy_clr        (rdy_clr),
        .DATA_OUT       (DATA_OUT),
        .n_INT          (n_INT),
        .dbg_tx_state_o (dbg_tx_state),
        .dbg_rx_state_o (dbg_rx_state)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];      // expected received bytes
    logic [0:0] exp_bit_q[$];  // expected TxD level at each bit centre
    logic [7:0] last_good;     // model of DATA_OUT
    int         n_checks = 0;
    int         n_fail   = 0;

    // ---------------- driver tasks ----------------
    task automatic tx_write(input logic [7:0] d);
        @(posedge clk); #1;
        DATA_IN = d;
        n_WR    = 1'b0;
        @(posedge clk); #1;
        n_WR    = 1'b1;
    endtask

    task automatic push_tx_bits(input logic [7:0] d, input int nbits);
        logic [10:0] f;
        f = {1'b1, ^d, d, 1'b0};
        for (int i = 0; i < nbits; i++) exp_bit_q.push_back(f[i]);
    endtask

    // Entered just after the edge that accepted the write: watches one whole frame.
    task automatic check_tx_frame(input logic [7:0] d, input string name);
        int low;
        logic [0:0] e;
        low = 0;
        push_tx_bits(d, 11);
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (!Tx_RDY) low++;
            if (k % DIV == DIV / 2) begin
                e = exp_bit_q.pop_front();
                n_checks++;
                if (TxD !== e[0]) begin
                    n_fail++;
                    $display("FAIL %s bit%0d: TxD=%b expected %b", name, k / DIV, TxD, e[0]);
                end
            end
        end
        n_checks++;
        if (low !== FRAME) begin
            n_fail++;
            $display("FAIL %s tx_rdy_low: %0d clocks expected %0d", name, low, FRAME);
        end
    endtask

    task automatic send_rx_frame(input logic [7:0] d, input logic par_bad,
                                 input logic stop_v, input int clks);
        logic [10:0] f;
        f = {stop_v, (^d) ^ par_bad, d, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 11; i++) begin
            RxD = f[i];
            repeat (clks) @(posedge clk);
            #1;
        end
        RxD = 1'b1;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        rdy_clr = 1'b1;
        @(posedge clk); #1;
        rdy_clr = 1'b0;
    endtask

    // Good frame: push the byte, then pop it once Rx_RDY appears.
    task automatic rx_good(input logic [7:0] d, input string name);
        logic [7:0] e;
        exp_q.push_back(d);
        send_rx_frame(d, 1'b0, 1'b1, SLOW_DIV);
        @(negedge clk);
        e = exp_q.pop_front();
        last_good = e;
        n_checks++;
        if (Rx_RDY !== 1'b1 || DATA_OUT !== e || n_INT !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: rdy=%b data=%h n_int=%b expected rdy=1 data=%h n_int=1",
                     name, Rx_RDY, DATA_OUT, n_INT, e);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1; n_WR = 1'b1; DATA_IN = 8'h00; RxD = 1'b1; rdy_clr = 1'b0;
        repeat (4) @(posedge clk);
        #1 RST = 1'b0;
        last_good = 8'h00;
        @(negedge clk);
        n_checks++;
        if (TxD !== 1'b1 || Tx_RDY !== 1'b1 || Rx_RDY !== 1'b0 || DATA_OUT !== 8'h00 || n_INT !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: TxD=%b Tx_RDY=%b Rx_RDY=%b DATA_OUT=%h n_INT=%b expected 1 1 0 00 1",
                     TxD, Tx_RDY, Rx_RDY, DATA_OUT, n_INT);
        end
    endtask

    task automatic test_tx();
        tx_write(8'h55);
        check_tx_frame(8'h55, "tx_55");
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (Tx_RDY !== 1'b1 || TxD !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_idle_after: Tx_RDY=%b TxD=%b expected 1 1", Tx_RDY, TxD);
        end
    endtask

    // n_WR held low: the second byte starts one clock after Tx_RDY returns.
    task automatic test_back_to_back();
        logic [7:0] a, b;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        DATA_IN = a;
        n_WR    = 1'b0;
        @(posedge clk); #1;
        DATA_IN = b;  // stays presented while busy; must not disturb frame a
        check_tx_frame(a, "b2b_a");
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (Tx_RDY !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gap: Tx_RDY=%b expected 1", Tx_RDY);
        end
        @(posedge clk); #1;
        n_WR = 1'b1;
        check_tx_frame(b, "b2b_b");
    endtask

    task automatic test_rx_good();
        rx_good(8'h09, "rx_09");
        rx_good(8'hA5, "rx_overrun");  // Rx_RDY still set: byte simply overwrites
        pulse_clr();
        @(negedge clk);
        n_checks++;
        if (Rx_RDY !== 1'b0 || DATA_OUT !== last_good) begin
            n_fail++;
            $display("FAIL rx_clr: Rx_RDY=%b DATA_OUT=%h expected 0 %h", Rx_RDY, DATA_OUT, last_good);
        end
    endtask

    task automatic test_rx_parity();
        for (int r = 0; r < 2; r++) begin
            send_rx_frame(8'h09, 1'b1, 1'b1, SLOW_DIV);
            @(negedge clk);
            n_checks++;
            if (Rx_RDY !== 1'b0 || n_INT !== 1'b0 || DATA_OUT !== last_good) begin
                n_fail++;
                $display("FAIL rx_parity%0d: Rx_RDY=%b n_INT=%b DATA_OUT=%h expected 0 0 %h",
                         r, Rx_RDY, n_INT, DATA_OUT, last_good);
            end
        end
        pulse_clr();
        @(negedge clk);
        n_checks++;
        if (n_INT !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_clr: n_INT=%b expected 1", n_INT);
        end
    endtask

    task automatic test_framing_glitch();
        send_rx_frame(8'h5A, 1'b0, 1'b0, SLOW_DIV);
        @(negedge clk);
        n_checks++;
        if (n_INT !== 1'b0 || Rx_RDY !== 1'b0 || DATA_OUT !== last_good) begin
            n_fail++;
            $display("FAIL framing: n_INT=%b Rx_RDY=%b DATA_OUT=%h expected 0 0 %h",
                     n_INT, Rx_RDY, DATA_OUT, last_good);
        end
        pulse_clr();
        repeat (20) @(posedge clk);
        #1 RxD = 1'b0;
        repeat (100) @(posedge clk);
        #1 RxD = 1'b1;
        repeat (400) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (dbg_rx_state !== ST_IDLE || n_INT !== 1'b1 || Rx_RDY !== 1'b0 || DATA_OUT !== last_good) begin
            n_fail++;
            $display("FAIL glitch: rx_state=%0d n_INT=%b Rx_RDY=%b DATA_OUT=%h expected 0 1 0 %h",
                     dbg_rx_state, n_INT, Rx_RDY, DATA_OUT, last_good);
        end
    endtask

    // Reset lands during data bit 4 (frame bit index 5); a late write is also dropped.
    task automatic test_reset_mid_frame();
        logic [0:0] e;
        tx_write(8'hA3);
        push_tx_bits(8'hA3, 5);
        for (int k = 0; k <= 2300; k++) begin
            @(negedge clk);
            if (k == 300) begin
                DATA_IN = 8'h00;
                n_WR    = 1'b0;
            end
            if (k == 302) n_WR = 1'b1;
            if (k % DIV == DIV / 2) begin
                e = exp_bit_q.pop_front();
                n_checks++;
                if (TxD !== e[0]) begin
                    n_fail++;
                    $display("FAIL rstmid bit%0d: TxD=%b expected %b", k / DIV, TxD, e[0]);
                end
            end
        end
        RST = 1'b1;
        @(posedge clk); #1;
        RST = 1'b0;
        last_good = 8'h00;
        @(negedge clk);
        n_checks++;
        if (TxD !== 1'b1 || Tx_RDY !== 1'b1 || dbg_tx_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL rst_mid_frame: TxD=%b Tx_RDY=%b expected 1 1", TxD, Tx_RDY);
        end
        rx_good(8'hC6, "rx_after_reset");
        pulse_clr();
    endtask

    task automatic test_full_duplex();
        logic [7:0] t, r;
        t = 8'($urandom_range(0, 255));
        r = 8'($urandom_range(0, 255));
        tx_write(t);
        fork
            check_tx_frame(t, "duplex_tx");
            rx_good(r, "duplex_rx");
        join
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        test_reset();
        test_tx();
        test_back_to_back();
        test_rx_good();
        test_rx_parity();
        test_framing_glitch();
        test_reset_mid_frame();
        test_full_duplex();
        repeat (10) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
